// File: rtl/pic_host_sequencer_pkg.sv
// Shared types and constants for the 8259A host-side sequencer.
package pic_pkg;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [3:0] {
    IDLE,
    W_ICW1,
    W_ICW2,
    W_ICW3,
    W_ICW4,
    W_OCW1,
    W_CMD,
    A_PULSE1,
    A_GAP,
    A_PULSE2,
    A_HOLD
  } state_t;

  typedef enum logic [1:0] {
    CMD_ILLEGAL = 2'b00,
    CMD_OCW1    = 2'b01,
    CMD_OCW2    = 2'b10,
    CMD_OCW3    = 2'b11
  } cmd_sel_t;

  typedef struct packed {
    logic icw1;
    logic icw24;
    logic ocw1;
    logic ocw2;
    logic ocw3;
  } strobe_t;

  // The timer expires when it reaches zero, so a span of N cycles loads N-1.
  function automatic logic [CNT_W-1:0] cnt_load(input int unsigned cycles);
    return CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/pic_host_sequencer_inta_timer.sv
// Down counter timing the INTA_n pulse and gap phases; saturates at zero.
module pic_inta_timer
  import pic_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_expired
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/pic_host_sequencer.sv
// Arbitrates init programming, host OCW commands and the INTA_n vector fetch
// onto the single 8259A write/acknowledge path.
module pic_host_sequencer
  import pic_pkg::*;
#(
  parameter int unsigned PULSE_CYCLES = 2,
  parameter int unsigned GAP_CYCLES   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cfg_start,
  input  logic [7:0] cfg_icw1,
  input  logic [7:0] cfg_icw2,
  input  logic [7:0] cfg_icw3,
  input  logic [7:0] cfg_icw4,
  input  logic [7:0] cfg_ocw1,
  output logic       cfg_busy,
  output logic       cfg_done,
  output logic       initialized,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_sel,
  input  logic [7:0] cmd_data,
  output logic       cmd_err,
  output logic [7:0] internal_bus,
  output logic       ICW_1,
  output logic       ICW_2_4,
  output logic       OCW_1,
  output logic       OCW_2,
  output logic       OCW_3,
  input  logic       ack_enable,
  input  logic       INT,
  output logic       INTA_n,
  input  logic [7:0] pic_data,
  output logic       vec_valid,
  input  logic       vec_ready,
  output logic [7:0] vec_data
);

  state_t           r_state;
  state_t           w_next;
  strobe_t          r_strb;
  strobe_t          w_strb;
  logic [7:0]       r_bus;
  logic [7:0]       w_bus;
  logic             w_cmd_err;
  logic             w_ack_elig;
  logic             w_tmr_load;
  logic [CNT_W-1:0] w_tmr_val;
  logic             w_tmr_exp;
  logic             w_init_next;
  logic [1:0]       r_icw1_mode;
  logic [7:0]       r_icw2;
  logic [7:0]       r_icw3;
  logic [7:0]       r_icw4;
  logic [7:0]       r_ocw1;
  logic             r_inta_n;
  logic             r_busy;
  logic             r_done;
  logic             r_init;
  logic             r_cmd_err;
  logic             r_vec_valid;
  logic [7:0]       r_vec_data;

  pic_inta_timer u_timer (
    .i_clk      (clk),
    .i_rst      (reset),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_expired  (w_tmr_exp)
  );

  assign w_ack_elig = INT & ack_enable & r_init & ~r_vec_valid;
  assign cmd_ready  = (r_state == IDLE) & ~cfg_start & ~w_ack_elig & r_init;

  always_comb begin
    w_next     = r_state;
    w_tmr_load = 1'b0;
    w_tmr_val  = cnt_load(PULSE_CYCLES);
    case (r_state)
      IDLE: begin
        if (cfg_start) begin
          w_next = W_ICW1;
        end else if (w_ack_elig) begin
          w_next     = A_PULSE1;
          w_tmr_load = 1'b1;
        end else if (cmd_valid && r_init) begin
          w_next = W_CMD;
        end
      end
      W_ICW1: w_next = W_ICW2;
      // icw1[1]=SNGL skips ICW3, icw1[0]=IC4 requests ICW4.
      W_ICW2: w_next = !r_icw1_mode[1] ? W_ICW3 : (r_icw1_mode[0] ? W_ICW4 : W_OCW1);
      W_ICW3: w_next = r_icw1_mode[0] ? W_ICW4 : W_OCW1;
      W_ICW4: w_next = W_OCW1;
      W_OCW1: w_next = IDLE;
      W_CMD:  w_next = IDLE;
      A_PULSE1: begin
        if (w_tmr_exp) begin
          w_next     = A_GAP;
          w_tmr_load = 1'b1;
          w_tmr_val  = cnt_load(GAP_CYCLES);
        end
      end
      A_GAP: begin
        if (w_tmr_exp) begin
          w_next     = A_PULSE2;
          w_tmr_load = 1'b1;
        end
      end
      A_PULSE2: if (w_tmr_exp) w_next = A_HOLD;
      A_HOLD:   w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  // Outputs are registered from the next state so each strobe lines up with its state.
  always_comb begin
    w_strb      = '0;
    w_bus       = r_bus;
    w_cmd_err   = 1'b0;
    w_init_next = 1'b0;
    case (w_next)
      W_ICW1: begin w_strb.icw1  = 1'b1; w_bus = cfg_icw1; w_init_next = 1'b1; end
      W_ICW2: begin w_strb.icw24 = 1'b1; w_bus = r_icw2;   w_init_next = 1'b1; end
      W_ICW3: begin w_strb.icw24 = 1'b1; w_bus = r_icw3;   w_init_next = 1'b1; end
      W_ICW4: begin w_strb.icw24 = 1'b1; w_bus = r_icw4;   w_init_next = 1'b1; end
      W_OCW1: begin w_strb.ocw1  = 1'b1; w_bus = r_ocw1;   w_init_next = 1'b1; end
      W_CMD: begin
        w_bus = cmd_data;
        case (cmd_sel_t'(cmd_sel))
          CMD_OCW1:    w_strb.ocw1 = 1'b1;
          CMD_OCW2:    w_strb.ocw2 = 1'b1;
          CMD_OCW3:    w_strb.ocw3 = 1'b1;
          CMD_ILLEGAL: w_cmd_err   = 1'b1;
          default:     w_cmd_err   = 1'b1;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_strb      <= '0;
      r_bus       <= '0;
      r_cmd_err   <= 1'b0;
      r_inta_n    <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_init      <= 1'b0;
      r_icw1_mode <= '0;
      r_icw2      <= '0;
      r_icw3      <= '0;
      r_icw4      <= '0;
      r_ocw1      <= '0;
      r_vec_valid <= 1'b0;
      r_vec_data  <= '0;
    end else begin
      r_strb    <= w_strb;
      r_bus     <= w_bus;
      r_cmd_err <= w_cmd_err;
      r_inta_n  <= ~((w_next == A_PULSE1) || (w_next == A_PULSE2));
      r_busy    <= w_init_next;
      r_done    <= (r_state == W_OCW1);
      if (r_state == W_OCW1) r_init <= 1'b1;
      if ((r_state == IDLE) && cfg_start) begin
        r_icw1_mode <= cfg_icw1[1:0];
        r_icw2      <= cfg_icw2;
        r_icw3      <= cfg_icw3;
        r_icw4      <= cfg_icw4;
        r_ocw1      <= cfg_ocw1;
      end
      if ((r_state == A_PULSE2) && w_tmr_exp) begin
        r_vec_data  <= pic_data;
        r_vec_valid <= 1'b1;
      end else if (r_vec_valid && vec_ready) begin
        r_vec_valid <= 1'b0;
      end
    end
  end

  assign ICW_1        = r_strb.icw1;
  assign ICW_2_4      = r_strb.icw24;
  assign OCW_1        = r_strb.ocw1;
  assign OCW_2        = r_strb.ocw2;
  assign OCW_3        = r_strb.ocw3;
  assign internal_bus = r_bus;
  assign cmd_err      = r_cmd_err;
  assign INTA_n       = r_inta_n;
  assign cfg_busy     = r_busy;
  assign cfg_done     = r_done;
  assign initialized  = r_init;
  assign vec_valid    = r_vec_valid;
  assign vec_data     = r_vec_data;

endmodule

// File: tb/tb_pic_host_sequencer.sv
// Directed bench for pic_host_sequencer with PULSE_CYCLES=2, GAP_CYCLES=1.
module tb_pic_host_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_start;
  logic [7:0] cfg_icw1, cfg_icw2, cfg_icw3, cfg_icw4, cfg_ocw1;
  logic       cfg_busy, cfg_done, initialized;
  logic       cmd_valid, cmd_ready;
  logic [1:0] cmd_sel;
  logic [7:0] cmd_data;
  logic       cmd_err;
  logic [7:0] internal_bus;
  logic       ICW_1, ICW_2_4, OCW_1, OCW_2, OCW_3;
  logic       ack_enable, INT, INTA_n;
  logic [7:0] pic_data;
  logic       vec_valid, vec_ready;
  logic [7:0] vec_data;
  logic [4:0] strb;

  int n_total = 0;
  int n_bad   = 0;

  pic_host_sequencer #(.PULSE_CYCLES(2), .GAP_CYCLES(1)) dut (
    .clk(clk), .reset(reset), .cfg_start(cfg_start),
    .cfg_icw1(cfg_icw1), .cfg_icw2(cfg_icw2), .cfg_icw3(cfg_icw3),
    .cfg_icw4(cfg_icw4), .cfg_ocw1(cfg_ocw1),
    .cfg_busy(cfg_busy), .cfg_done(cfg_done), .initialized(initialized),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sel(cmd_sel),
    .cmd_data(cmd_data), .cmd_err(cmd_err), .internal_bus(internal_bus),
    .ICW_1(ICW_1), .ICW_2_4(ICW_2_4), .OCW_1(OCW_1), .OCW_2(OCW_2), .OCW_3(OCW_3),
    .ack_enable(ack_enable), .INT(INT), .INTA_n(INTA_n), .pic_data(pic_data),
    .vec_valid(vec_valid), .vec_ready(vec_ready), .vec_data(vec_data)
  );

  always #5 clk = ~clk;

  // Strobe order: ICW_1, ICW_2_4, OCW_1, OCW_2, OCW_3
  assign strb = {ICW_1, ICW_2_4, OCW_1, OCW_2, OCW_3};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_init(input string name, input logic [7:0] i1, i2, i3, i4, o1,
                          input int n, input logic [0:4][4:0] es, input logic [0:4][7:0] eb);
    cfg_icw1 = i1; cfg_icw2 = i2; cfg_icw3 = i3; cfg_icw4 = i4; cfg_ocw1 = o1;
    cfg_start = 1'b1;
    for (int k = 0; k < n; k++) begin
      step();
      cfg_start = 1'b0;
      check_eq($sformatf("%s_strb%0d", name, k), strb, es[k]);
      check_eq($sformatf("%s_bus%0d", name, k), internal_bus, eb[k]);
      check_eq($sformatf("%s_busy%0d", name, k), cfg_busy, 1'b1);
      check_eq($sformatf("%s_done%0d", name, k), cfg_done, 1'b0);
    end
    step();
    check_eq({name, "_done"}, cfg_done, 1'b1);
    check_eq({name, "_idle_busy"}, cfg_busy, 1'b0);
    check_eq({name, "_idle_strb"}, strb, 5'b0);
    check_eq({name, "_init"}, initialized, 1'b1);
    step();
    check_eq({name, "_done_clr"}, cfg_done, 1'b0);
  endtask

  initial begin
    logic [0:5]      a_inta;
    logic [0:3][1:0] c_sel;
    logic [0:3][7:0] c_dat;
    logic [0:3][4:0] c_strb;
    logic [0:12][4:0] p_strb;
    logic [0:12]     p_inta;
    logic [0:12]     p_rdy;

    reset = 1'b1; cfg_start = 1'b0;
    cfg_icw1 = '0; cfg_icw2 = '0; cfg_icw3 = '0; cfg_icw4 = '0; cfg_ocw1 = '0;
    cmd_valid = 1'b0; cmd_sel = '0; cmd_data = '0;
    ack_enable = 1'b0; INT = 1'b0; pic_data = '0; vec_ready = 1'b0;
    step(); step();
    check_eq("rst_inta", INTA_n, 1'b1);
    check_eq("rst_strb", strb, 5'b0);
    check_eq("rst_bus", internal_bus, 8'h00);
    check_eq("rst_vec", {vec_valid, vec_data}, 9'h000);
    check_eq("rst_flags", {cfg_busy, cfg_done, cmd_err, initialized}, 4'b0);
    @(negedge clk);
    reset = 1'b0;

    // Commands before initialization are never accepted.
    cmd_valid = 1'b1; cmd_sel = 2'b01; cmd_data = 8'h77;
    #1 check_eq("preinit_rdy", cmd_ready, 1'b0);
    step(); step();
    check_eq("preinit_strb", strb, 5'b0);
    check_eq("preinit_rdy2", cmd_ready, 1'b0);
    cmd_valid = 1'b0;

    run_init("init13", 8'h13, 8'h20, 8'h99, 8'h01, 8'hFB, 4,
             {5'b10000, 5'b01000, 5'b01000, 5'b00100, 5'b0},
             {8'h13, 8'h20, 8'h01, 8'hFB, 8'h00});
    run_init("init10", 8'h10, 8'h20, 8'h04, 8'hAA, 8'hFB, 4,
             {5'b10000, 5'b01000, 5'b01000, 5'b00100, 5'b0},
             {8'h10, 8'h20, 8'h04, 8'hFB, 8'h00});
    run_init("init11", 8'h11, 8'h20, 8'h04, 8'h01, 8'hFB, 5,
             {5'b10000, 5'b01000, 5'b01000, 5'b01000, 5'b00100},
             {8'h11, 8'h20, 8'h04, 8'h01, 8'hFB});

    // Acknowledge: low 2, high 1, low 2, then hold with vector captured.
    ack_enable = 1'b1; INT = 1'b1;
    a_inta = 6'b001001;
    for (int k = 0; k < 6; k++) begin
      step();
      if (k == 3) pic_data = 8'h21;
      check_eq($sformatf("ack_inta%0d", k), INTA_n, a_inta[k]);
      check_eq($sformatf("ack_strb%0d", k), strb, 5'b0);
      check_eq($sformatf("ack_vv%0d", k), vec_valid, (k == 5) ? 1'b1 : 1'b0);
    end
    check_eq("ack_vec", vec_data, 8'h21);
    INT = 1'b0;
    step(); step(); step();
    check_eq("ack_vv_hold", vec_valid, 1'b1);
    check_eq("ack_no_reack", INTA_n, 1'b1);
    vec_ready = 1'b1;
    step();
    vec_ready = 1'b0;
    check_eq("ack_vv_clr", vec_valid, 1'b0);

    // Host commands, including the illegal selector.
    c_sel  = {2'b10, 2'b11, 2'b01, 2'b00};
    c_dat  = {8'h0B, 8'h48, 8'hFE, 8'h3C};
    c_strb = {5'b00010, 5'b00001, 5'b00100, 5'b00000};
    for (int i = 0; i < 4; i++) begin
      cmd_valid = 1'b1; cmd_sel = c_sel[i]; cmd_data = c_dat[i];
      #1 check_eq($sformatf("cmd%0d_rdy", i), cmd_ready, 1'b1);
      step();
      cmd_valid = 1'b0;
      check_eq($sformatf("cmd%0d_strb", i), strb, c_strb[i]);
      check_eq($sformatf("cmd%0d_err", i), cmd_err, (i == 3) ? 1'b1 : 1'b0);
      check_eq($sformatf("cmd%0d_busyrdy", i), cmd_ready, 1'b0);
      if (i != 3) check_eq($sformatf("cmd%0d_bus", i), internal_bus, c_dat[i]);
      step();
      check_eq($sformatf("cmd%0d_strb_clr", i), strb, 5'b0);
      check_eq($sformatf("cmd%0d_err_clr", i), cmd_err, 1'b0);
      check_eq($sformatf("cmd%0d_rdy_again", i), cmd_ready, 1'b1);
    end

    // Simultaneous init, interrupt and command: init, then ack, then command.
    cfg_icw1 = 8'h13; cfg_icw2 = 8'h20; cfg_icw4 = 8'h01; cfg_ocw1 = 8'hFB;
    cfg_start = 1'b1; INT = 1'b1; pic_data = 8'h27;
    cmd_valid = 1'b1; cmd_sel = 2'b01; cmd_data = 8'h55;
    #1 check_eq("prio_rdy0", cmd_ready, 1'b0);
    p_strb = {5'b10000, 5'b01000, 5'b01000, 5'b00100, 5'b0, 5'b0, 5'b0,
              5'b0, 5'b0, 5'b0, 5'b0, 5'b0, 5'b00100};
    p_inta = 13'b1111100100111;
    p_rdy  = 13'b0000000000010;
    for (int k = 0; k < 13; k++) begin
      step();
      cfg_start = 1'b0;
      if (k == 12) cmd_valid = 1'b0;
      check_eq($sformatf("prio_strb%0d", k + 1), strb, p_strb[k]);
      check_eq($sformatf("prio_inta%0d", k + 1), INTA_n, p_inta[k]);
      check_eq($sformatf("prio_rdy%0d", k + 1), cmd_ready, p_rdy[k]);
      if (k == 10) check_eq("prio_vec", vec_data, 8'h27);
    end
    check_eq("prio_cmd_bus", internal_bus, 8'h55);
    INT = 1'b0; vec_ready = 1'b1;
    step();
    vec_ready = 1'b0;
    check_eq("prio_vv_clr", vec_valid, 1'b0);

    // Reset in the second pulse, then re-init with INT still pending.
    INT = 1'b1; pic_data = 8'h2F;
    step(); step(); step(); step();
    check_eq("rp2_in_pulse2", INTA_n, 1'b0);
    #3 reset = 1'b1;
    #1;
    check_eq("rp2_inta", INTA_n, 1'b1);
    check_eq("rp2_vv", vec_valid, 1'b0);
    check_eq("rp2_init", initialized, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    step(); step();
    check_eq("rp2_noack_uninit", INTA_n, 1'b1);
    run_init("reinit", 8'h13, 8'h20, 8'h00, 8'h01, 8'hFB, 4,
             {5'b10000, 5'b01000, 5'b01000, 5'b00100, 5'b0},
             {8'h13, 8'h20, 8'h01, 8'hFB, 8'h00});
    check_eq("rp2_p1a", INTA_n, 1'b0);
    step();
    check_eq("rp2_p1b", INTA_n, 1'b0);
    step();
    check_eq("rp2_gap", INTA_n, 1'b1);
    step();
    check_eq("rp2_p2", INTA_n, 1'b0);
    INT = 1'b0;
    step(); step(); step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
